// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: drives one req/ack data-memory transaction per load/store and stalls IF..M until it completes.
// Optional build macro MISALIGN_TRAP_EN faults misaligned half/word accesses locally, without a bus cycle.
`timescale 1ns/1ps
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              mem_err_q, mem_err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              load_q, load_d;

  logic        access;
  logic [1:0]  off;
  logic        size_b;
  logic        size_h;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        misalign;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  // A store wins when both controls are high.
  assign access = MemReadM | MemWriteM;
  assign off    = AddrM[1:0];
  assign size_b = (Funct3M[1:0] == 2'b00);
  assign size_h = (Funct3M[1:0] == 2'b01);

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = WriteDataM;
    if (size_b) begin
      req_be    = 4'b0001 << off;
      req_wdata = {4{WriteDataM[7:0]}};
    end else if (size_h) begin
      req_be    = 4'b0011 << {off[1], 1'b0};
      req_wdata = {2{WriteDataM[15:0]}};
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = (size_h & off[0]) | (~size_b & ~size_h & (off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Lane select uses the offset/size captured at request time, not the live pipeline inputs.
  always_comb begin
    lane_b   = dmem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    load_ext = dmem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'b0, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'b0, lane_h};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    read_data_d = read_data_q;
    mem_err_d   = mem_err_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    load_d      = load_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misalign) begin
            state_d   = S_DONE;
            mem_err_d = 1'b1;
            if (!MemWriteM) read_data_d = '0;
          end else begin
            state_d  = S_BUSY;
            req_d    = 1'b1;
            count_d  = '0;
            we_d     = MemWriteM;
            addr_d   = {AddrM[31:2], 2'b00};
            be_d     = req_be;
            wdata_d  = req_wdata;
            funct3_d = Funct3M;
            off_d    = off;
            load_d   = ~MemWriteM;
          end
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (load_q) read_data_d = load_ext;
        end else if (count_q == CNT_LAST) begin
          req_d     = 1'b0;
          mem_err_d = 1'b1;
          state_d   = S_DONE;
          if (load_q) read_data_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        mem_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      read_data_q <= '0;
      mem_err_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      mem_err_q   <= mem_err_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      load_q      <= load_d;
    end
  end

  // The stall drops in DONE so the pipeline advances exactly once per access.
  assign StallM     = access & (state_q != S_DONE);
  assign ReadDataM  = read_data_q;
  assign MemErrM    = mem_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver pushes expected bus/completion records, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;
  localparam int BUDGET  = TIMEOUT + 8;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM, WriteDataM, ReadDataM;
  logic        StallM, MemErrM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .MemErrM(MemErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stalls;
  } done_t;

  bus_t  bus_q[$];
  done_t done_q[$];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          ack_delay = -1;
  logic [31:0] resp_rdata = '0;
  int          stray_req = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Memory responder: acks ack_delay cycles into a request; a stray ack fires only while no request is up.
  initial begin
    int busy_cnt;
    int stray_seen;
    busy_cnt   = 0;
    stray_seen = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (reset && dmem_req) begin
        if (busy_cnt == ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = resp_rdata;
        end
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        if (stray_seen != stray_req) begin
          dmem_ack = 1'b1;
          stray_seen++;
        end
      end
    end
  end

  // Monitor: bus fields on request rise and while held, results when the stall drops with an access present.
  initial begin
    int   stall_run;
    logic req_prev;
    bus_t cur;
    bus_t b;
    done_t d;
    logic access;
    logic held;
    stall_run = 0;
    req_prev  = 1'b0;
    cur       = '{addr: '0, we: 1'b0, be: '0, wdata: '0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_run = 0;
        req_prev  = 1'b0;
      end else begin
        if (dmem_req && !req_prev) begin
          if (bus_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_req: actual addr=%h, required no request", dmem_addr);
          end else begin
            b = bus_q.pop_front();
            cur = b;
            check("dmem_addr", dmem_addr, b.addr);
            check("dmem_we", {31'b0, dmem_we}, {31'b0, b.we});
            check("dmem_be", {28'b0, dmem_be}, {28'b0, b.be});
            if (b.we) check("dmem_wdata", dmem_wdata, b.wdata);
          end
        end else if (dmem_req) begin
          held = (dmem_addr == cur.addr) && (dmem_we == cur.we) && (dmem_be == cur.be) &&
                 (!cur.we || dmem_wdata == cur.wdata);
          check("bus_hold", {31'b0, held}, 32'd1);
        end
        req_prev = dmem_req;
        access = MemReadM | MemWriteM;
        if (!access) begin
          stall_run = 0;
          check("stall_no_access", {31'b0, StallM}, 32'd0);
        end else if (StallM) begin
          stall_run++;
        end else begin
          if (done_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_done: actual stall released, required no completion");
          end else begin
            d = done_q.pop_front();
            check("ReadDataM", ReadDataM, d.rd);
            check("MemErrM", {31'b0, MemErrM}, {31'b0, d.err});
            check("stall_cycles", stall_run, d.stalls);
          end
          stall_run = 0;
        end
        if (!(access && !StallM)) check("err_outside_done", {31'b0, MemErrM}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference model from the access rules; delay<0 means the memory never acks.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int delay, input logic [31:0] rdata);
    int          off, sz;
    logic        mis, tout, is_ld, done_seen;
    logic [31:0] v;
    bus_t        b;
    done_t       d;
    off   = int'(addr[1:0]);
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    is_ld = rd && !wr;
    mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 2 && (off % 2) != 0) || (sz == 4 && off != 0);
`endif
    tout = !mis && (delay < 0);
    b.addr = addr - 32'(off);
    b.we   = wr;
    if (sz == 1) begin
      b.be    = 4'(1 << off);
      b.wdata = wd[7:0] * 32'h0101_0101;
      v = (rdata >> (8 * off)) & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2) begin
      b.be    = 4'(3 << (2 * (off / 2)));
      b.wdata = wd[15:0] * 32'h0001_0001;
      v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      b.be    = 4'hF;
      b.wdata = wd;
      v = rdata;
    end
    if (!is_ld)         d.rd = last_rd;
    else if (mis||tout) d.rd = '0;
    else                d.rd = v;
    last_rd  = d.rd;
    d.err    = mis || tout;
    d.stalls = mis ? 1 : tout ? 1 + TIMEOUT : delay + 2;
    if (!mis) bus_q.push_back(b);
    done_q.push_back(d);

    ack_delay  = delay;
    resp_rdata = rdata;
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    AddrM      = addr;
    WriteDataM = wd;
    done_seen  = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk); #1;
      if (!StallM) begin
        done_seen = 1'b1;
        break;
      end
    end
    if (!done_seen) begin
      n_cmp++; n_fail++;
      $display("FAIL op_complete: actual stall still high after %0d cycles, required completion", BUDGET);
      finish_run();
    end
    @(posedge clk); #1;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = '0;
    AddrM      = '0;
    WriteDataM = '0;
    #2;
    check("rst_ReadDataM", ReadDataM, 32'h0);
    check("rst_MemErrM", {31'b0, MemErrM}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_StallM", {31'b0, StallM}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'h0);
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F);
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h80FF_FF7F);
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 2, 32'h8001_0000);
    do_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 0, 32'h0);
    do_op(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 3, 32'h8001_0000);
    do_op(1'b1, 1'b1, 3'b000, 32'h0000_0201, 32'hA5A5_A5C3, 1, 32'h1234_5678);
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, -1, 32'h0);
    stray_req++;
    idle(2);
    do_op(1'b0, 1'b1, 3'b000, 32'h0000_0204, 32'h0000_0077, -1, 32'h0);
    stray_req++;
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0208, 32'h0, 2, 32'h0BAD_CAFE);
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'hCAFE_F00D);
    do_op(1'b0, 1'b1, 3'b101, 32'h0000_0103, 32'h0000_BEEF, 0, 32'h0);
    do_op(1'b1, 1'b0, 3'b111, 32'h0000_0106, 32'h0, 1, 32'h1357_9BDF);

    // Reset pulsed in the middle of a bus transaction
    begin
      bus_t b;
      b.addr = 32'h300; b.we = 1'b0; b.be = 4'hF; b.wdata = '0;
      bus_q.push_back(b);
      ack_delay = -1;
      Funct3M   = 3'b010;
      AddrM     = 32'h0000_0300;
      MemReadM  = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("req_before_reset", {31'b0, dmem_req}, 32'd1);
      reset    = 1'b0;
      MemReadM = 1'b0;
      #1;
      check("mid_rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("mid_rst_StallM", {31'b0, StallM}, 32'd0);
      check("mid_rst_ReadDataM", ReadDataM, 32'h0);
      check("mid_rst_dmem_be", {28'b0, dmem_be}, 32'd0);
      check("mid_rst_dmem_addr", dmem_addr, 32'h0);
      bus_q.delete();
      done_q.delete();
      last_rd = '0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
    end
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'h0F0F_0F0F, 0, 32'h0);
    do_op(1'b1, 1'b0, 3'b001, 32'h0000_0306, 32'h0, 1, 32'h7FFF_0001);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      int          kind, dly;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom_range(0, 7));
      dly  = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) stray_req++;
      do_op(kind != 1, kind != 0, f3, $urandom, $urandom, dly, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    finish_run();
  end

endmodule
